inst_queue: RTL

- Front-end producer for the decoder.
- Runs a single-outstanding fetch FSM against the instruction cache, walking sequentially from the current fetch PC.
- Buffers returned instructions with their PCs in a circular FIFO and presents the head entry to the decoder through a valid/enable handshake.
- A ROB flush (mispredict/redirect) empties the FIFO, redirects the fetch PC and discards any in-flight cache response.

---
 rtl/inst_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/inst_queue.sv
// Instruction fetch queue: single-outstanding ICache fetch FSM feeding a circular
// FIFO of {inst, pc} entries that the decoder pops through a valid/enable handshake.
module inst_queue #(
  parameter int unsigned DEPTH_LOG = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        IC_req,
  output logic [31:0] IC_addr,
  input  logic        IC_valid,
  input  logic [31:0] IC_inst,
  input  logic        DC_enable,
  output logic        DC_inst_valid,
  output logic [31:0] DC_inst,
  output logic [31:0] DC_pc,
  input  logic        ROB_flush,
  input  logic [31:0] ROB_target_pc
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam int unsigned CW    = DEPTH_LOG + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t               mem_q [DEPTH];
  state_e               state_q,    state_d;
  logic [DEPTH_LOG-1:0] head_q,     head_d;
  logic [DEPTH_LOG-1:0] tail_q,     tail_d;
  logic [CW-1:0]        count_q,    count_d;
  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic                 ic_req_q,   ic_req_d;
  logic [31:0]          ic_addr_q,  ic_addr_d;
  logic                 push;
  logic                 pop;

  // Next-state: fetch FSM, FIFO pointers and fetch PC; flush overrides push and pop.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (rdy) begin
      unique case (state_q)
        S_IDLE: begin
          if (!ROB_flush && (count_q < CW'(DEPTH))) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (IC_valid) begin
            state_d = S_IDLE;
            push    = !ROB_flush;
          end else if (ROB_flush) begin
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (IC_valid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (ROB_flush) begin
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        fetch_pc_d = ROB_target_pc;
      end else begin
        pop = DC_enable && (count_q != '0);
        if (push) begin
          tail_d     = tail_q + DEPTH_LOG'(1);
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (pop) head_d = head_q + DEPTH_LOG'(1);
        count_d = count_q + CW'(push) - CW'(pop);
      end
    end
    // Request is only driven while waiting; address is zero otherwise.
    ic_req_d  = (state_d == S_WAIT);
    ic_addr_d = ic_req_d ? fetch_pc_d : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      ic_req_q   <= 1'b0;
      ic_addr_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      ic_req_q   <= ic_req_d;
      ic_addr_q  <= ic_addr_d;
    end
  end

  // Entry storage needs no reset; empty slots are masked at the decoder port.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{inst: IC_inst, pc: fetch_pc_q};
  end

  assign IC_req        = ic_req_q;
  assign IC_addr       = ic_addr_q;
  assign DC_inst_valid = (count_q != '0);
  assign DC_inst       = DC_inst_valid ? mem_q[head_q].inst : 32'h0;
  assign DC_pc         = DC_inst_valid ? mem_q[head_q].pc   : 32'h0;

endmodule
